// File: rtl/uart_arb_pkg.sv
// Shared types and elaboration helpers for the UART transmit arbiter and its
// round-robin selector.
package uart_arb_pkg;

  typedef enum logic [2:0] {IDLE, SEND, WAIT, FETCH, RELEASE} arb_state_e;

  localparam int GID_W         = 3;
  localparam int N_REQ_MIN     = 2;
  localparam int N_REQ_MAX     = 8;
  localparam int MAX_BURST_DEF = 16;
  localparam int TIMEOUT_DEF   = 20000;

  function automatic bit n_req_ok(input int n);
    return (n >= N_REQ_MIN) && (n <= N_REQ_MAX);
  endfunction

  // Watchdog counts 0..TIMEOUT-1, so $clog2(TIMEOUT) bits suffice.
  function automatic int wdog_w(input int timeout);
    return (timeout > 1) ? $clog2(timeout) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Client byte streams plus the UART transmitter start/busy/done handshake.
interface uart_tx_arbiter_if #(
  parameter int N_REQ = 4
) ();
  logic [N_REQ-1:0]   req;
  logic [8*N_REQ-1:0] req_data;
  logic [N_REQ-1:0]   req_last;
  logic [N_REQ-1:0]   ack;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               tx_busy;
  logic               tx_done;

  modport master (
    input  req, req_data, req_last, tx_busy, tx_done,
    output ack, tx_start, tx_data
  );

  modport slave (
    output req, req_data, req_last, tx_busy, tx_done,
    input  ack, tx_start, tx_data
  );
endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector: first set req bit at or above rr_ptr,
// wrapping modulo N_REQ.
module uart_rr_pick
  import uart_arb_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0] req,
  input  logic [GID_W-1:0] rr_ptr,
  output logic             any,
  output logic [GID_W-1:0] winner
);

  int               idx;
  logic [N_REQ-1:0] req_sh;

  // Scan from the farthest offset down so the nearest requester wins last.
  always_comb begin
    any    = |req;
    winner = '0;
    idx    = 0;
    req_sh = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      idx    = (int'(rr_ptr) + i) % N_REQ;
      req_sh = req >> idx;
      if (req_sh[0]) winner = GID_W'(idx);
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter sharing one UART transmitter between
// N_REQ byte-stream clients, with a watchdog on the transmitter's done pulse.
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int MAX_BURST = MAX_BURST_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rstn,
  uart_tx_arbiter_if.master bus,
  output logic              grant_valid,
  output logic [GID_W-1:0]  grant_id,
  output logic              timeout_err
);

  localparam int WDOG_W = wdog_w(TIMEOUT);

  generate
    if (!n_req_ok(N_REQ)) begin : g_bad_n_req
      $error("uart_tx_arbiter: N_REQ must be in 2..8");
    end
  endgenerate

  arb_state_e        state_q, state_d;
  logic [GID_W-1:0]  rr_q, rr_d, gid_q, gid_d, winner, sel;
  logic [N_REQ-1:0]  ack_q, ack_d, sel_oh;
  logic              start_q, start_d, gv_q, gv_d, terr_q, terr_d;
  logic              last_q, last_d, any_req, sel_last, own_req;
  logic [7:0]        data_q, data_d, sel_data, burst_q, burst_d;
  logic [WDOG_W-1:0] wdog_q, wdog_d;

  uart_rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req    (bus.req),
    .rr_ptr (rr_q),
    .any    (any_req),
    .winner (winner)
  );

  // In IDLE the candidate is the round-robin winner; afterwards only the owner.
  assign sel      = (state_q == IDLE) ? winner : gid_q;
  assign sel_oh   = N_REQ'(1) << sel;
  assign sel_data = 8'(bus.req_data >> {sel, 3'b000});
  assign sel_last = |(bus.req_last & sel_oh);
  assign own_req  = |(bus.req & sel_oh);

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    ack_d   = '0;
    start_d = 1'b0;
    data_d  = data_q;
    gv_d    = gv_q;
    gid_d   = gid_q;
    terr_d  = 1'b0;
    burst_d = burst_q;
    wdog_d  = wdog_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          data_d  = sel_data;
          last_d  = sel_last;
          ack_d   = sel_oh;
          gid_d   = winner;
          gv_d    = 1'b1;
          burst_d = 8'd1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!bus.tx_busy) begin
          start_d = 1'b1;
          wdog_d  = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // tx_done takes priority over a coincident watchdog expiry.
        if (bus.tx_done) begin
          state_d = (last_q || (burst_q == 8'(MAX_BURST))) ? RELEASE : FETCH;
        end else if (wdog_q == WDOG_W'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          state_d = RELEASE;
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end
      FETCH: begin
        if (own_req) begin
          data_d  = sel_data;
          last_d  = sel_last;
          ack_d   = sel_oh;
          burst_d = burst_q + 8'd1;
          state_d = SEND;
        end else begin
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        rr_d    = (gid_q == GID_W'(N_REQ - 1)) ? '0 : gid_q + 1'b1;
        gv_d    = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      rr_q    <= '0;
      ack_q   <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      gv_q    <= 1'b0;
      gid_q   <= '0;
      terr_q  <= 1'b0;
      burst_q <= '0;
      wdog_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      ack_q   <= ack_d;
      start_q <= start_d;
      data_q  <= data_d;
      gv_q    <= gv_d;
      gid_q   <= gid_d;
      terr_q  <= terr_d;
      burst_q <= burst_d;
      wdog_q  <= wdog_d;
      last_q  <= last_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.tx_start = start_q;
  assign bus.tx_data  = data_q;
  assign grant_valid  = gv_q;
  assign grant_id     = gid_q;
  assign timeout_err  = terr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: client FIFOs, a transmitter model,
// directed corner cases, an arbitration vector table and a randomized phase.
module tb_uart_tx_arbiter;

  localparam int NR = 4;
  localparam int MB = 4;
  localparam int TO = 50;

  logic       clk, rstn;
  logic       grant_valid;
  logic [2:0] grant_id;
  logic       timeout_err;

  uart_tx_arbiter_if #(.N_REQ(NR)) bus ();

  uart_tx_arbiter #(.N_REQ(NR), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus),
    .grant_valid (grant_valid),
    .grant_id    (grant_id),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks, failures, cyc;
  int start_cnt, start_cycle, terr_cnt, terr_cycle, rel_cycle;
  int tx_cnt, tx_len, no_done, m_rr;
  bit busy_force, prev_force;
  logic [7:0]  cur_byte;
  logic [8:0]  cbuf [NR][512];
  int          chead [NR];
  int          ctail [NR];
  int          ack_log [$];
  logic [10:0] tx_log [$];
  logic [10:0] exp_q [$];

  typedef struct {
    int         prev;
    logic [3:0] mask;
    int         win;
  } arb_vec_t;
  arb_vec_t vec [8];

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, expv);
    end
  endtask

  task automatic push(input int c, input logic [7:0] b, input logic l);
    cbuf[c][ctail[c]] = {l, b};
    ctail[c]++;
  endtask

  function automatic bit all_empty();
    for (int i = 0; i < NR; i++) if (chead[i] < ctail[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [10:0] get_tx(input int i);
    if (i < tx_log.size()) return tx_log[i];
    return 11'h7ff;
  endfunction

  task automatic wait_idle(input int budget, input string nm);
    int quiet, n;
    quiet = 0;
    n = 0;
    while (quiet < 3 && n < budget) begin
      @(negedge clk);
      n++;
      if (all_empty() && !grant_valid && !bus.tx_busy && tx_cnt == 0) quiet++;
      else quiet = 0;
    end
    if (quiet < 3) chk({nm, "_idle_timeout"}, n, -1);
  endtask

  task automatic wait_ack(input int abase, input int budget, output int who);
    int n;
    n = 0;
    who = -1;
    while (ack_log.size() <= abase && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (ack_log.size() > abase) who = ack_log[abase];
  endtask

  task automatic wait_start(input int sc, input int budget);
    int n;
    n = 0;
    while (start_cnt <= sc && n < budget) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic cmp_log(input string nm, input int base);
    chk({nm, "_count"}, tx_log.size() - base, exp_q.size());
    foreach (exp_q[k]) chk(nm, get_tx(base + k), exp_q[k]);
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_ack"}, bus.ack, 0);
    chk({nm, "_tx_start"}, bus.tx_start, 0);
    chk({nm, "_tx_data"}, bus.tx_data, 0);
    chk({nm, "_grant_valid"}, grant_valid, 0);
    chk({nm, "_grant_id"}, grant_id, 0);
    chk({nm, "_timeout_err"}, timeout_err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    for (int i = 0; i < NR; i++) chead[i] = ctail[i];
    tx_cnt = 0;
    busy_force = 1'b0;
    no_done = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    m_rr = 0;
  endtask

  // Reference: serve whole queues by plain round-robin packet rules.
  task automatic predict();
    int h [NR];
    int ptr, w, c, n;
    bit stop;
    logic [8:0] e;
    exp_q.delete();
    for (int i = 0; i < NR; i++) h[i] = chead[i];
    ptr = m_rr;
    while (1) begin
      w = -1;
      for (int k = 0; k < NR; k++) begin
        c = (ptr + k) % NR;
        if (w < 0 && h[c] < ctail[c]) w = c;
      end
      if (w < 0) break;
      n = 0;
      stop = 1'b0;
      while (!stop) begin
        e = cbuf[w][h[w]];
        h[w]++;
        n++;
        exp_q.push_back({3'(w), e[7:0]});
        stop = e[8] || (n == MB) || (h[w] == ctail[w]);
      end
      ptr = (w + 1) % NR;
    end
    m_rr = ptr;
  endtask

  // Environment: monitors, client FIFOs and transmitter model, once per cycle.
  initial begin
    bus.req = '0;
    bus.req_data = '0;
    bus.req_last = '0;
    bus.tx_busy = 1'b0;
    bus.tx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      bus.tx_done = 1'b0;
      if (rstn) begin
        if (bus.ack != '0) begin
          chk("ack_onehot", $countones(bus.ack), 1);
          for (int i = 0; i < NR; i++)
            if (bus.ack[i]) begin
              ack_log.push_back(i);
              if (chead[i] < ctail[i]) chead[i]++;
            end
        end
        if (bus.tx_start) begin
          tx_log.push_back({grant_id, bus.tx_data});
          start_cnt++;
          start_cycle = cyc;
        end
        if (timeout_err) begin
          terr_cnt++;
          terr_cycle = cyc;
        end
      end
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          if (no_done > 0) no_done--;
          else begin
            bus.tx_done = 1'b1;
            chk("tx_data_stable", bus.tx_data, cur_byte);
          end
        end
      end else if (bus.tx_start && rstn) begin
        tx_cnt = tx_len;
        cur_byte = bus.tx_data;
      end
      if (prev_force && !busy_force) rel_cycle = cyc;
      prev_force = busy_force;
      bus.tx_busy = busy_force || (tx_cnt > 0);
      for (int i = 0; i < NR; i++) begin
        if (chead[i] < ctail[i]) begin
          bus.req[i] = 1'b1;
          bus.req_data[8*i +: 8] = cbuf[i][chead[i]][7:0];
          bus.req_last[i] = cbuf[i][chead[i]][8];
        end else begin
          bus.req[i] = 1'b0;
          bus.req_last[i] = 1'b0;
        end
      end
    end
  end

  initial begin
    int base, abase, sc, who, s1, t0, nb;
    vec[0] = '{prev: 3, mask: 4'b1011, win: 0};
    vec[1] = '{prev: 0, mask: 4'b1011, win: 1};
    vec[2] = '{prev: 1, mask: 4'b1011, win: 3};
    vec[3] = '{prev: 3, mask: 4'b1111, win: 0};
    vec[4] = '{prev: 2, mask: 4'b0011, win: 0};
    vec[5] = '{prev: 0, mask: 4'b0001, win: 0};
    vec[6] = '{prev: 2, mask: 4'b1100, win: 3};
    vec[7] = '{prev: 1, mask: 4'b0010, win: 1};
    tx_len = 10;
    rstn = 1'b1;
    #1 rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rstn = 1'b1;

    // Single client, two-byte packet.
    base = tx_log.size();
    abase = ack_log.size();
    push(2, 8'h41, 1'b0);
    push(2, 8'h42, 1'b1);
    exp_q.delete();
    exp_q.push_back({3'd2, 8'h41});
    exp_q.push_back({3'd2, 8'h42});
    wait_idle(300, "single");
    chk("single_ack_count", ack_log.size() - abase, 2);
    cmp_log("single_tx", base);
    // rr_ptr should now be 3: all four request, client 3 wins.
    abase = ack_log.size();
    for (int i = 0; i < NR; i++) push(i, 8'h50 + 8'(i), 1'b1);
    wait_ack(abase, 50, who);
    chk("rr_after_single", who, 3);
    wait_idle(400, "rr_after_single");

    // Arbitration vector table.
    foreach (vec[e]) begin
      push(vec[e].prev, 8'h60, 1'b1);
      wait_idle(200, "vec_prev");
      sc = start_cnt;
      abase = ack_log.size();
      for (int i = 0; i < NR; i++) if (vec[e].mask[i]) push(i, 8'h70 + 8'(i), 1'b1);
      wait_ack(abase, 50, who);
      chk("vec_winner", who, vec[e].win);
      wait_idle(400, "vec_drain");
      chk("vec_starts", start_cnt - sc, $countones(vec[e].mask));
    end

    // Burst limit with a competing client arriving mid-grant.
    base = tx_log.size();
    abase = ack_log.size();
    for (int k = 0; k < 10; k++) push(1, 8'h10 + 8'(k), 1'b0);
    wait_ack(abase, 50, who);
    for (int k = 0; k < 3; k++) push(0, 8'h20 + 8'(k), k == 2);
    exp_q.delete();
    for (int k = 0; k < 4; k++) exp_q.push_back({3'd1, 8'h10 + 8'(k)});
    for (int k = 0; k < 3; k++) exp_q.push_back({3'd0, 8'h20 + 8'(k)});
    for (int k = 4; k < 10; k++) exp_q.push_back({3'd1, 8'h10 + 8'(k)});
    wait_idle(2000, "burst");
    cmp_log("burst_tx", base);

    // Request dropped after a non-last byte.
    base = tx_log.size();
    sc = start_cnt;
    push(3, 8'h55, 1'b0);
    wait_idle(300, "reqdrop");
    repeat (20) @(negedge clk);
    chk("reqdrop_starts", start_cnt - sc, 1);
    chk("reqdrop_byte", get_tx(base), {3'd3, 8'h55});
    chk("reqdrop_grant_valid", grant_valid, 0);

    // Watchdog: first byte never gets tx_done.
    base = tx_log.size();
    sc = start_cnt;
    t0 = terr_cnt;
    no_done = 1;
    push(1, 8'hc1, 1'b1);
    wait_start(sc, 50);
    s1 = start_cycle;
    push(2, 8'hc2, 1'b1);
    exp_q.delete();
    exp_q.push_back({3'd1, 8'hc1});
    exp_q.push_back({3'd2, 8'hc2});
    wait_idle(400, "wdog");
    chk("wdog_err_pulses", terr_cnt - t0, 1);
    chk("wdog_err_latency", terr_cycle - s1, TO);
    cmp_log("wdog_tx", base);

    // Busy hold, then asynchronous reset in WAIT.
    busy_force = 1'b1;
    repeat (2) @(negedge clk);
    sc = start_cnt;
    push(2, 8'ha5, 1'b1);
    repeat (30) @(negedge clk);
    chk("busy_hold_no_start", start_cnt - sc, 0);
    busy_force = 1'b0;
    wait_start(sc, 50);
    chk("busy_release_latency", start_cycle - rel_cycle, 1);
    repeat (3) @(negedge clk);
    chk("wait_grant_valid", grant_valid, 1);
    chk("wait_grant_id", grant_id, 2);
    #2 rstn = 1'b0;
    #1 check_reset_outputs("async_reset");
    for (int i = 0; i < NR; i++) chead[i] = ctail[i];
    tx_cnt = 0;
    @(negedge clk);
    rstn = 1'b1;
    sc = start_cnt;
    repeat (30) @(negedge clk);
    chk("post_reset_no_start", start_cnt - sc, 0);

    // Randomized rounds against the packet-level reference.
    do_reset();
    for (int r = 0; r < 6; r++) begin
      tx_len = $urandom_range(2, 8);
      base = tx_log.size();
      for (int c = 0; c < NR; c++) begin
        nb = $urandom_range(0, 6);
        for (int k = 0; k < nb; k++) push(c, 8'($urandom), $urandom_range(0, 3) == 0);
      end
      predict();
      wait_idle(3000, "rand");
      cmp_log("rand_tx", base);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
